// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and data memory.
// Hits complete combinationally; misses stall the pipeline while a block writeback/refill runs.
module dcache_ctrl #(
    parameter int LINES = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  data_i,
    input  logic         MemRead_i,
    input  logic         MemWrite_i,
    output logic [31:0]  data_o,
    output logic         stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [1:0]   dbg_state_o
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 27 - IW;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic [TW-1:0]    r_tag  [LINES];
    logic [255:0]     r_data [LINES];

    logic [IW-1:0]  w_index;
    logic [TW-1:0]  w_tag;
    logic [7:0]     w_bitsel;
    logic           w_req;
    logic           w_hit;
    logic           w_store_hit;
    logic [255:0]   w_line;
    logic [31:0]    w_word;
    logic           w_unused_addr;

    assign w_index       = addr_i[5+IW-1:5];
    assign w_tag         = addr_i[31:5+IW];
    assign w_bitsel      = {addr_i[4:2], 5'b0};
    assign w_unused_addr = &{1'b0, addr_i[1:0]};
    assign w_req         = MemRead_i | MemWrite_i;
    assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_line        = r_data[w_index];
    assign w_word        = w_line[w_bitsel +: 32];
    assign w_store_hit   = (r_state == S_IDLE) && MemWrite_i && w_hit;

    // Valid/dirty bits and FSM state are the only reset-cleared storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_ALLOCATE && mem_ack_i) begin
                r_valid[w_index] <= 1'b1;
                r_dirty[w_index] <= 1'b0;
            end else if (w_store_hit) begin
                r_dirty[w_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (r_state == S_ALLOCATE && mem_ack_i) begin
                r_data[w_index] <= mem_data_i;
                r_tag[w_index]  <= w_tag;
            end else if (w_store_hit) begin
                r_data[w_index][w_bitsel +: 32] <= data_i;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    if (r_valid[w_index] && r_dirty[w_index])
                        w_next_state = S_WRITEBACK;
                    else
                        w_next_state = S_ALLOCATE;
                end
            end
            S_WRITEBACK: if (mem_ack_i) w_next_state = S_ALLOCATE;
            S_ALLOCATE:  if (mem_ack_i) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // The held CPU address supplies index and refill tag, so memory outputs stay constant per transaction.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        stall_o      = 1'b0;
        data_o       = '0;
        case (r_state)
            S_IDLE: begin
                stall_o = w_req && !w_hit;
                if (MemRead_i && !stall_o)
                    data_o = w_word;
            end
            S_WRITEBACK: begin
                stall_o      = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {r_tag[w_index], w_index, 5'b0};
                mem_data_o   = w_line;
            end
            S_ALLOCATE: begin
                stall_o      = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {w_tag, w_index, 5'b0};
            end
            default: stall_o = 1'b1;
        endcase
    end

    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a hit-vector table plus hand-written miss, eviction and reset sequences.
module tb_dcache_ctrl;

    logic         clk;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [31:0]  data_i;
    logic         MemRead_i;
    logic         MemWrite_i;
    logic [31:0]  data_o;
    logic         stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [1:0]   dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_ctrl #(.LINES(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .data_o      (data_o),
        .stall_o     (stall_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i),
        .dbg_state_o (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] blk(input logic [31:0] base);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[32*w +: 32] = base + w;
        return b;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = addr;
        data_i     = wdata;
    endtask

    // Acts as memory: acks the writeback on its wb_lat-th cycle and the refill on its al_lat-th cycle.
    task automatic serve(input int wb_lat, input int al_lat, input logic [255:0] refill,
                         output int stalls, output bit saw_wb, output logic [31:0] wb_addr,
                         output logic [255:0] wb_data, output logic [31:0] al_addr);
        int wb_cnt = 0;
        int al_cnt = 0;
        int drift  = 0;
        stalls  = 0;
        saw_wb  = 0;
        wb_addr = '0;
        wb_data = '0;
        al_addr = '0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!stall_o) break;
            stalls++;
            if (mem_enable_o && mem_write_o) begin
                if (wb_cnt == 0) begin
                    wb_addr = mem_addr_o;
                    wb_data = mem_data_o;
                    saw_wb  = 1;
                end else if (mem_addr_o !== wb_addr) begin
                    drift++;
                end
                wb_cnt++;
                if (wb_cnt == wb_lat) mem_ack_i = 1'b1;
            end else if (mem_enable_o) begin
                if (al_cnt == 0) al_addr = mem_addr_o;
                else if (mem_addr_o !== al_addr) drift++;
                al_cnt++;
                if (al_cnt == al_lat) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = refill;
                end
            end
            @(posedge clk);
            #1;
            mem_ack_i  = 1'b0;
            mem_data_i = '0;
        end
        chk("stall_released", stall_o, 1'b0);
        chk("mem_addr_stable", drift, 0);
    endtask

    int           stalls;
    bit           saw_wb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    logic [31:0]  al_addr;
    logic [255:0] exp_blk;

    initial begin
        rst_i      = 1'b1;
        addr_i     = '0;
        data_i     = '0;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        mem_data_i = '0;
        mem_ack_i  = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1000_0000};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_000C, 32'hAAAA_5555, 1'b0, 32'h1000_0003};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         1'b0, 32'hAAAA_5555};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_001F, 32'h0,         1'b0, 32'h1000_0007};

        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_state", dbg_state_o, 2'd0);
        chk("rst_mem_enable", mem_enable_o, 1'b0);
        chk("rst_mem_write", mem_write_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 256'h0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_data", data_o, 32'h0);

        // Clean miss on line 0, ack on the third refill cycle.
        exp_blk = blk(32'h1000_0000);
        exp_blk[63:32] = 32'hDEAD_BEEF;
        drive(1'b1, 1'b0, 32'h0000_0004, 32'h0);
        serve(0, 3, exp_blk, stalls, saw_wb, wb_addr, wb_data, al_addr);
        chk("miss1_stalls", stalls, 4);
        chk("miss1_no_wb", saw_wb, 1'b0);
        chk("miss1_al_addr", al_addr, 32'h0);
        chk("miss1_data", data_o, 32'hDEAD_BEEF);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), stall_o, vecs[i].exp_stall);
            chk($sformatf("vec%0d_data", i), data_o, vecs[i].exp_data);
            chk($sformatf("vec%0d_mem_en", i), mem_enable_o, 1'b0);
        end

        // Dirty miss on line 0: writeback of tag 0, then refill of 0x400.
        drive(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        serve(2, 1, blk(32'h2000_0000), stalls, saw_wb, wb_addr, wb_data, al_addr);
        chk("evict0_stalls", stalls, 4);
        chk("evict0_saw_wb", saw_wb, 1'b1);
        chk("evict0_wb_addr", wb_addr, 32'h0);
        chk("evict0_wb_word2", wb_data[95:64], 32'h1234_5678);
        chk("evict0_wb_word3", wb_data[127:96], 32'hAAAA_5555);
        chk("evict0_al_addr", al_addr, 32'h0000_0400);
        chk("evict0_data", data_o, 32'h2000_0000);

        // Store miss on clean line 1, then the merged word must read back.
        drive(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
        serve(0, 1, blk(32'h3000_0000), stalls, saw_wb, wb_addr, wb_data, al_addr);
        chk("stmiss_stalls", stalls, 2);
        chk("stmiss_no_wb", saw_wb, 1'b0);
        chk("stmiss_al_addr", al_addr, 32'h0000_0020);
        chk("stmiss_data_zero", data_o, 32'h0);
        drive(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        serve(0, 1, 256'h0, stalls, saw_wb, wb_addr, wb_data, al_addr);
        chk("stmiss_rd_stalls", stalls, 0);
        chk("stmiss_rd_data", data_o, 32'hCAFE_F00D);

        exp_blk = blk(32'h3000_0000);
        exp_blk[31:0] = 32'hCAFE_F00D;
        drive(1'b1, 1'b0, 32'h0000_0420, 32'h0);
        serve(1, 1, blk(32'h4000_0000), stalls, saw_wb, wb_addr, wb_data, al_addr);
        chk("evict1_stalls", stalls, 3);
        chk("evict1_wb_addr", wb_addr, 32'h0000_0020);
        chk("evict1_wb_data", wb_data, exp_blk);
        chk("evict1_al_addr", al_addr, 32'h0000_0420);
        chk("evict1_data", data_o, 32'h4000_0000);

        // Read+write on a clean hit: old word out, new word stored, line becomes dirty.
        drive(1'b1, 1'b1, 32'h0000_0424, 32'h5A5A_5A5A);
        serve(0, 1, 256'h0, stalls, saw_wb, wb_addr, wb_data, al_addr);
        chk("rdwr_stalls", stalls, 0);
        chk("rdwr_old_word", data_o, 32'h4000_0001);
        exp_blk = blk(32'h4000_0000);
        exp_blk[63:32] = 32'h5A5A_5A5A;
        drive(1'b1, 1'b0, 32'h0000_0024, 32'h0);
        serve(1, 2, blk(32'h5000_0000), stalls, saw_wb, wb_addr, wb_data, al_addr);
        chk("rdwr_evict_stalls", stalls, 4);
        chk("rdwr_evict_saw_wb", saw_wb, 1'b1);
        chk("rdwr_evict_wb_addr", wb_addr, 32'h0000_0420);
        chk("rdwr_evict_wb_data", wb_data, exp_blk);
        chk("rdwr_evict_data", data_o, 32'h5000_0001);

        // Reset during ALLOCATE, followed by a late ack.
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        @(negedge clk);
        chk("rstmid_c0_stall", stall_o, 1'b1);
        chk("rstmid_c0_mem_en", mem_enable_o, 1'b0);
        @(negedge clk);
        chk("rstmid_c1_mem_en", mem_enable_o, 1'b1);
        chk("rstmid_c1_state", dbg_state_o, 2'd2);
        chk("rstmid_c1_addr", mem_addr_o, 32'h0000_0040);
        rst_i     = 1'b1;
        MemRead_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i      = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = blk(32'h7000_0000);
        @(negedge clk);
        chk("rstmid_mem_en", mem_enable_o, 1'b0);
        chk("rstmid_stall", stall_o, 1'b0);
        chk("rstmid_state", dbg_state_o, 2'd0);
        chk("rstmid_addr", mem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        @(negedge clk);
        chk("lateack_state", dbg_state_o, 2'd0);
        chk("lateack_mem_en", mem_enable_o, 1'b0);

        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        serve(0, 1, blk(32'h6000_0000), stalls, saw_wb, wb_addr, wb_data, al_addr);
        chk("post_rst_miss_stalls", stalls, 2);
        chk("post_rst_miss_data", data_o, 32'h6000_0000);

        // Line 0 held 0x400 before reset; the cleared valid bit forces a clean refill.
        drive(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        serve(0, 1, blk(32'h8000_0000), stalls, saw_wb, wb_addr, wb_data, al_addr);
        chk("post_rst_line0_stalls", stalls, 2);
        chk("post_rst_line0_no_wb", saw_wb, 1'b0);
        chk("post_rst_line0_data", data_o, 32'h8000_0001);

        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("final_idle_stall", stall_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
